time_set_sequencer: RTL

- Edit and commit controller for the real-time-clock time registers (hours, minutes, seconds).
- In run mode it mirrors the live binary time read back from the RTC. Its binary hour output feeds the existing 24-hour binary-to-BCD hour converter, which drives the display.
- In edit mode it freezes a shadow copy and lets the user select a field and step it up or down with wrap-around.
- On commit it sequences three BCD register writes to the RTC bus interface over a req/ack handshake.

---
 rtl/time_set_sequencer.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/time_set_sequencer.sv
// -----------------------------------------------------------------------------
// time_set_sequencer
//   Edit/commit controller for the RTC time registers. In IDLE the shadow
//   registers mirror the live RTC readback (out-of-range values load as 0).
//   In EDIT the shadow is frozen and the user steps the selected field with
//   wrap-around. On commit, three BCD register writes (hours, minutes,
//   seconds) are issued over a req/ack handshake. Each write has an ack
//   timeout that aborts the rest of the sequence.
//
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   btn_set/up/down/       debounced button levels, acted on at rising edge
//   right/left
//   hora_in/min_in/seg_in  live binary time from RTC readback
//   hora_out/min_out/      shadow binary time (hora_out feeds hour converter)
//   seg_out
//   edit_mode, field_sel   EDIT indicator, selected field (0=h, 1=m, 2=s)
//   busy, err              write sequence active, one-cycle timeout pulse
//   wr_req/wr_addr/        register write request, address, packed BCD data
//   wr_data, wr_ack        and acknowledge from the bus interface
// -----------------------------------------------------------------------------
module time_set_sequencer #(
  parameter logic [7:0]  ADDR_HORA   = 8'h23,
  parameter logic [7:0]  ADDR_MIN    = 8'h22,
  parameter logic [7:0]  ADDR_SEG    = 8'h21,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic [4:0] hora_in,
  input  logic [5:0] min_in,
  input  logic [5:0] seg_in,
  output logic [4:0] hora_out,
  output logic [5:0] min_out,
  output logic [5:0] seg_out,
  output logic       edit_mode,
  output logic [1:0] field_sel,
  output logic       busy,
  output logic       err,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ack
);

  // The counter only has to reach ACK_TIMEOUT-1: wr_req is high for
  // exactly ACK_TIMEOUT cycles before a write is abandoned.
  localparam int unsigned CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EDIT = 3'd1,
    ST_WR_H = 3'd2,
    ST_WR_M = 3'd3,
    ST_WR_S = 3'd4
  } state_t;

  // Binary 0..59 to packed BCD by repeated compare-subtract of ten.
  function automatic logic [7:0] to_bcd(input logic [5:0] value);
    logic [5:0] rem;
    logic [3:0] tens;
    rem  = value;
    tens = 4'd0;
    for (int i = 0; i < 5; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end else begin
        tens = tens;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  // One step up or down within 0..top, wrapping at both ends.
  function automatic logic [5:0] wrap_step(input logic [5:0] value,
                                           input logic [5:0] top,
                                           input logic       up);
    logic [5:0] res;
    if (up) begin
      res = (value >= top) ? 6'd0 : value + 6'd1;
    end else begin
      res = (value == 6'd0) ? top : value - 6'd1;
    end
    return res;
  endfunction

  state_t        state_r, state_nx_s;
  logic [4:0]    btn_s, btn_prev_r, btn_edge_s;
  logic          set_e_s, up_act_s, dn_act_s, right_act_s, left_act_s;
  logic [4:0]    hora_r, hora_nx_s, hora_live_s;
  logic [5:0]    min_r, min_nx_s, min_live_s;
  logic [5:0]    seg_r, seg_nx_s, seg_live_s;
  logic [5:0]    hora_step_s, min_step_s, seg_step_s;
  logic [1:0]    field_r, field_nx_s;
  logic          req_r, req_nx_s;
  logic [7:0]    addr_r, addr_nx_s, data_r, data_nx_s;
  logic [7:0]    tgt_addr_s, tgt_data_s;
  state_t        tgt_next_s;
  logic          err_r, err_nx_s;
  logic          edit_r, busy_r;
  logic [CW-1:0] cnt_r, cnt_nx_s;

  // Rising edges; opposing pairs pressed together cancel each other.
  assign btn_s       = {btn_set, btn_up, btn_down, btn_right, btn_left};
  assign btn_edge_s  = btn_s & ~btn_prev_r;
  assign set_e_s     = btn_edge_s[4];
  assign up_act_s    = btn_edge_s[3] & ~btn_edge_s[2];
  assign dn_act_s    = btn_edge_s[2] & ~btn_edge_s[3];
  assign right_act_s = btn_edge_s[1] & ~btn_edge_s[0];
  assign left_act_s  = btn_edge_s[0] & ~btn_edge_s[1];

  assign hora_live_s = (hora_in > 5'd23) ? 5'd0 : hora_in;
  assign min_live_s  = (min_in  > 6'd59) ? 6'd0 : min_in;
  assign seg_live_s  = (seg_in  > 6'd59) ? 6'd0 : seg_in;

  assign hora_step_s = wrap_step({1'b0, hora_r}, 6'd23, up_act_s);
  assign min_step_s  = wrap_step(min_r, 6'd59, up_act_s);
  assign seg_step_s  = wrap_step(seg_r, 6'd59, up_act_s);

  // Address, data and successor state of the write owned by the current state.
  always_comb begin
    tgt_addr_s = ADDR_HORA;
    tgt_data_s = to_bcd({1'b0, hora_r});
    tgt_next_s = ST_WR_M;
    case (state_r)
      ST_WR_M: begin
        tgt_addr_s = ADDR_MIN;
        tgt_data_s = to_bcd(min_r);
        tgt_next_s = ST_WR_S;
      end
      ST_WR_S: begin
        tgt_addr_s = ADDR_SEG;
        tgt_data_s = to_bcd(seg_r);
        tgt_next_s = ST_IDLE;
      end
      default: begin
        tgt_addr_s = ADDR_HORA;
        tgt_data_s = to_bcd({1'b0, hora_r});
        tgt_next_s = ST_WR_M;
      end
    endcase
  end

  // Next-state and next-value logic for the FSM and its datapath.
  always_comb begin
    state_nx_s = state_r;
    hora_nx_s  = hora_r;
    min_nx_s   = min_r;
    seg_nx_s   = seg_r;
    field_nx_s = field_r;
    req_nx_s   = req_r;
    addr_nx_s  = addr_r;
    data_nx_s  = data_r;
    err_nx_s   = 1'b0;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        hora_nx_s = hora_live_s;
        min_nx_s  = min_live_s;
        seg_nx_s  = seg_live_s;
        if (set_e_s) begin
          state_nx_s = ST_EDIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_EDIT: begin
        if (set_e_s) begin
          state_nx_s = ST_WR_H;
        end else begin
          if (up_act_s || dn_act_s) begin
            case (field_r)
              2'd0:    hora_nx_s = hora_step_s[4:0];
              2'd1:    min_nx_s  = min_step_s;
              2'd2:    seg_nx_s  = seg_step_s;
              default: hora_nx_s = hora_r;
            endcase
          end else begin
            hora_nx_s = hora_r;
          end
          if (right_act_s) begin
            field_nx_s = (field_r >= 2'd2) ? 2'd0 : field_r + 2'd1;
          end else if (left_act_s) begin
            field_nx_s = (field_r == 2'd0) ? 2'd2 : field_r - 2'd1;
          end else begin
            field_nx_s = field_r;
          end
        end
      end
      ST_WR_H, ST_WR_M, ST_WR_S: begin
        // Low wr_req in a write state means this write has not been issued
        // yet; after an ack the state advances in the same cycle, which
        // leaves exactly one low gap cycle before the next request.
        if (!req_r) begin
          req_nx_s  = 1'b1;
          cnt_nx_s  = {CW{1'b0}};
          addr_nx_s = tgt_addr_s;
          data_nx_s = tgt_data_s;
        end else if (wr_ack) begin
          req_nx_s   = 1'b0;
          state_nx_s = tgt_next_s;
        end else if (cnt_r == CNT_LAST) begin
          req_nx_s   = 1'b0;
          err_nx_s   = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        req_nx_s   = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath, button history and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_prev_r <= 5'd0;
      hora_r     <= 5'd0;
      min_r      <= 6'd0;
      seg_r      <= 6'd0;
      field_r    <= 2'd0;
      req_r      <= 1'b0;
      addr_r     <= 8'd0;
      data_r     <= 8'd0;
      err_r      <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      edit_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      btn_prev_r <= btn_s;
      hora_r     <= hora_nx_s;
      min_r      <= min_nx_s;
      seg_r      <= seg_nx_s;
      field_r    <= field_nx_s;
      req_r      <= req_nx_s;
      addr_r     <= addr_nx_s;
      data_r     <= data_nx_s;
      err_r      <= err_nx_s;
      cnt_r      <= cnt_nx_s;
      edit_r     <= (state_nx_s == ST_EDIT);
      busy_r     <= (state_nx_s == ST_WR_H) || (state_nx_s == ST_WR_M) ||
                    (state_nx_s == ST_WR_S);
    end
  end

  assign hora_out  = hora_r;
  assign min_out   = min_r;
  assign seg_out   = seg_r;
  assign field_sel = field_r;
  assign edit_mode = edit_r;
  assign busy      = busy_r;
  assign err       = err_r;
  assign wr_req    = req_r;
  assign wr_addr   = addr_r;
  assign wr_data   = data_r;

endmodule
